// File: rtl/reg_file_pkg.sv
// Shared definitions for the bypassing register file: default parameters
// and the sequencer state encoding.
package reg_file_pkg;

  localparam int DEFAULT_WIDTH    = 64;
  localparam int DEFAULT_DEPTH    = 16;
  localparam int DEFAULT_SELECT   = 4;
  localparam int DEFAULT_ZERO_REG = 0;

  // INIT sweeps the storage to zero one entry per cycle, RUN serves requests.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/reg_file_init_ctrl.sv
// Start-up sequencer: after reset it walks an index over every register so
// the storage can be cleared, then raises ready for the rest of operation.
module reg_file_init_ctrl
  import reg_file_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int SELECT = DEFAULT_SELECT
) (
  input  logic              clock,
  input  logic              reset,
  output logic              ready,
  output logic              clear_en,
  output logic [SELECT-1:0] index
);

  localparam logic [SELECT-1:0] LAST_INDEX = SELECT'(DEPTH - 1);

  state_t            state;
  state_t            state_next;
  logic [SELECT-1:0] index_next;

  // State and sweep index register; reset always restarts the sweep at entry 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INIT;
      index <= '0;
    end else begin
      state <= state_next;
      index <= index_next;
    end
  end

  // Advance the sweep one entry per cycle and leave INIT once the last entry is cleared.
  always_comb begin
    state_next = state;
    index_next = index;
    ready      = 1'b0;
    clear_en   = 1'b0;
    case (state)
      INIT: begin
        clear_en = 1'b1;
        if (index == LAST_INDEX) begin
          state_next = RUN;
          index_next = '0;
        end else begin
          index_next = index + 1'b1;
        end
      end
      RUN: begin
        ready = 1'b1;
      end
      default: begin
        state_next = INIT;
        index_next = '0;
      end
    endcase
  end

endmodule

// File: rtl/reg_file_bypass.sv
// Two-read, one-write register file with byte strobes, registered read data
// and write-to-read bypass so a same-cycle read sees the freshly merged word.
module reg_file_bypass
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int SELECT   = DEFAULT_SELECT,
  parameter int ZERO_REG = DEFAULT_ZERO_REG
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cs,
  input  logic                 re,
  input  logic                 we,
  input  logic [SELECT-1:0]    read_reg1,
  input  logic [SELECT-1:0]    read_reg2,
  input  logic [SELECT-1:0]    write_register,
  input  logic [WIDTH-1:0]     write_data,
  input  logic [WIDTH/8-1:0]   write_strobe,
  output logic [WIDTH-1:0]     read_data1,
  output logic [WIDTH-1:0]     read_data2,
  output logic                 read_valid,
  output logic                 ready,
  output logic                 access_err
);

  localparam int NBYTES = WIDTH / 8;

  logic [WIDTH-1:0]  regs [DEPTH];
  logic              clear_en;
  logic [SELECT-1:0] index;
  logic              rd_accept;
  logic              wr_hit;
  logic [WIDTH-1:0]  write_word;
  logic [WIDTH-1:0]  rd_word1;
  logic [WIDTH-1:0]  rd_word2;

  // Addresses beyond the populated range behave as unbacked zero locations.
  function automatic logic addr_ok(input logic [SELECT-1:0] addr);
    return int'(addr) < DEPTH;
  endfunction

  // With ZERO_REG set, entry 0 is hardwired to zero.
  function automatic logic is_zero_reg(input logic [SELECT-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // Replace only the bytes whose strobe bit is set.
  function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0]  old_word,
                                                   input logic [WIDTH-1:0]  new_word,
                                                   input logic [NBYTES-1:0] strobe);
    logic [WIDTH-1:0] result;
    result = old_word;
    for (int b = 0; b < NBYTES; b++) begin
      if (strobe[b]) result[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return result;
  endfunction

  reg_file_init_ctrl #(
    .DEPTH  (DEPTH),
    .SELECT (SELECT)
  ) u_init_ctrl (
    .clock    (clock),
    .reset    (reset),
    .ready    (ready),
    .clear_en (clear_en),
    .index    (index)
  );

  assign rd_accept  = cs & re & ready & ~reset;
  assign wr_hit     = cs & we & ready & ~reset & addr_ok(write_register) & ~is_zero_reg(write_register);
  assign write_word = merge_bytes(regs[write_register], write_data, write_strobe);

  // Read-port muxes: stored word, patched with the in-flight write on an address match.
  always_comb begin
    rd_word1 = '0;
    rd_word2 = '0;
    if (addr_ok(read_reg1) && !is_zero_reg(read_reg1)) begin
      rd_word1 = regs[read_reg1];
      if (wr_hit && (read_reg1 == write_register)) rd_word1 = write_word;
    end
    if (addr_ok(read_reg2) && !is_zero_reg(read_reg2)) begin
      rd_word2 = regs[read_reg2];
      if (wr_hit && (read_reg2 == write_register)) rd_word2 = write_word;
    end
  end

  // Storage update: the start-up sweep clears entries, afterwards strobed writes merge in.
  always_ff @(posedge clock) begin
    if (clear_en) begin
      regs[index] <= '0;
    end else if (wr_hit) begin
      regs[write_register] <= write_word;
    end
  end

  // Registered read data, valid pulse and error pulse for requests made before ready.
  always_ff @(posedge clock) begin
    if (reset) begin
      read_data1 <= '0;
      read_data2 <= '0;
      read_valid <= 1'b0;
      access_err <= 1'b0;
    end else begin
      read_valid <= rd_accept;
      access_err <= cs & (re | we) & ~ready;
      if (rd_accept) begin
        read_data1 <= rd_word1;
        read_data2 <= rd_word2;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_bypass.sv
// Bench for reg_file_bypass: two instances (ZERO_REG 0 and 1) share stimulus,
// expected read words are queued when a read is driven and compared on read_valid.
module tb_reg_file_bypass;

  logic        clock;
  logic        reset;
  logic        cs;
  logic        re;
  logic        we;
  logic [3:0]  read_reg1;
  logic [3:0]  read_reg2;
  logic [3:0]  write_register;
  logic [63:0] write_data;
  logic [7:0]  write_strobe;

  logic [63:0] read_data1, read_data2, read_data1_z, read_data2_z;
  logic        read_valid, ready, access_err;
  logic        read_valid_z, ready_z, access_err_z;

  typedef struct packed {
    logic [63:0] d1;
    logic [63:0] d2;
    logic [63:0] z1;
    logic [63:0] z2;
  } exp_t;

  exp_t        sb [$];
  exp_t        last_exp;
  logic [63:0] mdl   [16];
  logic [63:0] mdl_z [16];
  int          total = 0;
  int          bad   = 0;

  reg_file_bypass #(.WIDTH(64), .DEPTH(16), .SELECT(4), .ZERO_REG(0)) dut (
    .clock(clock), .reset(reset), .cs(cs), .re(re), .we(we),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .write_register(write_register),
    .write_data(write_data), .write_strobe(write_strobe),
    .read_data1(read_data1), .read_data2(read_data2), .read_valid(read_valid),
    .ready(ready), .access_err(access_err)
  );

  reg_file_bypass #(.WIDTH(64), .DEPTH(16), .SELECT(4), .ZERO_REG(1)) dut_z (
    .clock(clock), .reset(reset), .cs(cs), .re(re), .we(we),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .write_register(write_register),
    .write_data(write_data), .write_strobe(write_strobe),
    .read_data1(read_data1_z), .read_data2(read_data2_z), .read_valid(read_valid_z),
    .ready(ready_z), .access_err(access_err_z)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Byte-strobe merge built from a byte mask.
  function automatic logic [63:0] mergeModel(input logic [63:0] old_word, input logic [63:0] wd,
                                             input logic [7:0] ws);
    logic [63:0] mask;
    mask = '0;
    for (int b = 0; b < 8; b++) mask |= (ws[b] ? 64'hFF : 64'h0) << (8 * b);
    return (old_word & ~mask) | (wd & mask);
  endfunction

  // Expected read result for one port of one instance.
  function automatic logic [63:0] expWord(input logic [63:0] stored, input bit zero_addr, input bit hit,
                                          input logic [63:0] wd, input logic [7:0] ws);
    if (zero_addr) return 64'h0;
    if (hit) return mergeModel(stored, wd, ws);
    return stored;
  endfunction

  task automatic clearModels();
    for (int i = 0; i < 16; i++) begin
      mdl[i]   = 64'h0;
      mdl_z[i] = 64'h0;
    end
    last_exp = '0;
  endtask

  // One request cycle: queue expected read data, drive, clock, update model, compare.
  task automatic applyStimulus(input bit do_rd, input logic [3:0] r1, input logic [3:0] r2,
                               input bit do_wr, input logic [3:0] wa,
                               input logic [63:0] wd, input logic [7:0] ws);
    exp_t e;
    if (do_rd) begin
      e.d1 = expWord(mdl[r1],   1'b0,     do_wr && (wa == r1), wd, ws);
      e.d2 = expWord(mdl[r2],   1'b0,     do_wr && (wa == r2), wd, ws);
      e.z1 = expWord(mdl_z[r1], r1 == 0,  do_wr && (wa == r1), wd, ws);
      e.z2 = expWord(mdl_z[r2], r2 == 0,  do_wr && (wa == r2), wd, ws);
      sb.push_back(e);
    end
    cs = 1'b1; re = do_rd; we = do_wr;
    read_reg1 = r1; read_reg2 = r2;
    write_register = wa; write_data = wd; write_strobe = ws;
    @(posedge clock); #1;
    cs = 1'b0; re = 1'b0; we = 1'b0;
    if (do_wr) begin
      mdl[wa] = mergeModel(mdl[wa], wd, ws);
      if (wa != 0) mdl_z[wa] = mergeModel(mdl_z[wa], wd, ws);
    end
    if (do_rd) begin
      checkOutput("read_valid", 64'(read_valid), 64'd1);
      checkOutput("read_valid_z", 64'(read_valid_z), 64'd1);
      if (sb.size() == 0) begin
        checkOutput("scoreboard_empty", 64'd0, 64'd1);
      end else begin
        last_exp = sb.pop_front();
        checkOutput("read_data1", read_data1, last_exp.d1);
        checkOutput("read_data2", read_data2, last_exp.d2);
        checkOutput("read_data1_z", read_data1_z, last_exp.z1);
        checkOutput("read_data2_z", read_data2_z, last_exp.z2);
      end
    end else begin
      checkOutput("read_valid_idle", 64'(read_valid), 64'd0);
      checkOutput("hold_data1", read_data1, last_exp.d1);
      checkOutput("hold_data2_z", read_data2_z, last_exp.z2);
    end
  endtask

  // Count cycles from reset release until ready; optionally poke a write during INIT.
  task automatic countInit(input string tag, input bit poke);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(posedge clock); #1;
      n++;
      if (poke && n == 3) begin
        checkOutput("err_pulse", 64'(access_err), 64'd1);
        checkOutput("err_pulse_z", 64'(access_err_z), 64'd1);
        cs = 1'b0; we = 1'b0;
      end
      if (poke && n == 4) checkOutput("err_clear", 64'(access_err), 64'd0);
      if (poke && n == 2) begin
        cs = 1'b1; we = 1'b1; write_register = 4'd1;
        write_data = 64'hFFFF_FFFF_FFFF_FFFF; write_strobe = 8'hFF;
      end
      if (ready) seen = 1;
    end
    checkOutput(tag, 64'(n), 64'd16);
    checkOutput({tag, "_z"}, 64'(ready_z), 64'd1);
  endtask

  task automatic readAllZero();
    for (int a = 0; a < 16; a += 2)
      applyStimulus(1'b1, 4'(a), 4'(a + 1), 1'b0, 4'd0, 64'h0, 8'h0);
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; re = 1'b0; we = 1'b0;
    read_reg1 = '0; read_reg2 = '0; write_register = '0;
    write_data = '0; write_strobe = '0;
    clearModels();
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_ready", 64'(ready), 64'd0);
    checkOutput("rst_read_valid", 64'(read_valid), 64'd0);
    checkOutput("rst_access_err", 64'(access_err), 64'd0);
    checkOutput("rst_read_data1", read_data1, 64'h0);
    checkOutput("rst_read_data2", read_data2, 64'h0);
    reset = 1'b0;
    countInit("ready_latency", 1'b0);
    readAllZero();

    $display("[TB] strobed write and partial overwrite");
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd5, 64'h1122334455667788, 8'hFF);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    applyStimulus(1'b1, 4'd5, 4'd5, 1'b0, 4'd0, 64'h0, 8'h0);
    checkOutput("reg5_value", last_exp.d1, 64'h11223344AAAAAAAA);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 64'h0, 8'h0);

    $display("[TB] same-cycle bypass");
    applyStimulus(1'b1, 4'd3, 4'd3, 1'b1, 4'd3, 64'h000000000000DEAD, 8'h03);
    checkOutput("bypass_value", last_exp.d2, 64'h000000000000DEAD);

    $display("[TB] zero register behaviour");
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd0, 64'h000000000000FFFF, 8'hFF);
    applyStimulus(1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 64'h0, 8'h0);
    checkOutput("reg0_plain", last_exp.d1, 64'h000000000000FFFF);
    checkOutput("reg0_zero", last_exp.z1, 64'h0);
    applyStimulus(1'b1, 4'd0, 4'd5, 1'b1, 4'd0, 64'h0000000000001234, 8'h03);

    $display("[TB] zero-strobe write");
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd5, 64'hFFFFFFFFFFFFFFFF, 8'h00);
    applyStimulus(1'b1, 4'd5, 4'd3, 1'b0, 4'd0, 64'h0, 8'h0);

    $display("[TB] random traffic");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    {$urandom, $urandom}, 8'($urandom_range(0, 255)));
    end

    $display("[TB] reset in RUN, then again at INIT index 7");
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (7) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    checkOutput("midinit_ready", 64'(ready), 64'd0);
    reset = 1'b0;
    clearModels();
    countInit("ready_after_restart", 1'b1);
    readAllZero();

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_bypass.md
REG_FILE_BYPASS -- requirements
Module: reg_file_bypass

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 16, number of registers.
REQ-003 SHALL have parameter SELECT, default 4, address width; SELECT = clog2(DEPTH).
REQ-004 SHALL have parameter ZERO_REG, default 0; when 1, register 0 reads as all-zeros and ignores writes.
REQ-005 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port cs  input  1  chip select; gates re and we.
REQ-008 SHALL have port re  input  1  read request.
REQ-009 SHALL have port we  input  1  write request.
REQ-010 SHALL have ports read_reg1, read_reg2  input  SELECT  read addresses.
REQ-011 SHALL have port write_register  input  SELECT  write address.
REQ-012 SHALL have port write_data  input  WIDTH  write data.
REQ-013 SHALL have port write_strobe  input  WIDTH/8  per-byte write enable; bit i covers write_data[8i+7:8i].
REQ-014 SHALL have ports read_data1, read_data2  output  WIDTH  registered read data.
REQ-015 SHALL have port read_valid  output  1  one-cycle pulse marking new read_data.
REQ-016 SHALL have port ready  output  1  high when the block accepts requests.
REQ-017 SHALL have port access_err  output  1  one-cycle pulse on a request while not ready.

Function
REQ-018 SHALL have FSM states INIT and RUN; INIT clears one register per cycle using an index counter 0..DEPTH-1.
REQ-019 SHALL transition INIT->RUN in the cycle after index DEPTH-1 is cleared; ready = (state == RUN).
REQ-020 SHALL accept a read when cs & re & ready: read_data1/2 capture addressed contents at that edge; read_valid high the following cycle only.
REQ-021 SHALL hold read_data1/2 unchanged in cycles with no accepted read.
REQ-022 SHALL perform a write when cs & we & ready: each byte of register[write_register] with write_strobe bit set takes write_data; other bytes are unchanged.
REQ-023 SHALL allow read and write in the same cycle; a read whose address equals write_register returns merged data (new bytes where strobe set, old bytes elsewhere).
REQ-024 SHALL treat both read ports independently; both may address the same register or the write target.
REQ-025 SHALL, when ZERO_REG=1, return zero for address 0 on either port, including under bypass, and discard writes to address 0.
REQ-026 SHALL ignore addresses >= DEPTH: reads return zero, writes are discarded.
REQ-027 SHALL ignore re/we while not ready and pulse access_err one cycle later if cs & (re | we) was high.
REQ-028 SHALL treat write_strobe = 0 with we high as an accepted no-op write.

Reset
REQ-029 SHALL, on reset high at a rising edge, set state=INIT, index=0, read_data1/2=0, read_valid=0, access_err=0, ready=0.
REQ-030 SHALL leave ready low for exactly DEPTH cycles after the first edge with reset low, after which all registers read zero.
REQ-031 SHALL restart INIT from index 0 if reset is asserted mid-INIT or during RUN.

Structure
REQ-032 SHALL place the state enum (INIT, RUN) and default parameter values in shared package reg_file_pkg.
REQ-033 SHALL implement the INIT sequencer (state, index, ready) as sub-module reg_file_init_ctrl; storage, bypass and read registers stay in the top.

Verification
REQ-034 SHALL check reset then idle: ready rises exactly DEPTH (16) cycles after reset drops; reads of addresses 0..15 return 0.
REQ-035 SHALL check write 0x1122334455667788 to reg 5 strobe 0xFF, then strobe 0x0F with 0xAAAAAAAAAAAAAAAA -> read reg 5 = 0x11223344AAAAAAAA, read_valid one cycle.
REQ-036 SHALL check same-cycle write reg 3 = 0xDEAD (strobe 0x03) with read_reg1 = read_reg2 = 3 -> both read 0xDEAD on the next cycle.
REQ-037 SHALL check ZERO_REG=1: write 0xFFFF to reg 0 -> read reg 0 = 0; same write with ZERO_REG=0 -> read reg 0 = 0xFFFF.
REQ-038 SHALL check reset at INIT index 7, and cs & we during INIT -> INIT restarts with full 16-cycle count, access_err pulses, no register changes.
